// File: rtl/alu_mc_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the multi-cycle ALU.

package alu_mc_pkg;

    localparam logic [3:0] OP_ROL  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_ROR  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_MULH = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_REM  = 4'b1011;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix
    } state_e;

    function automatic logic is_iter(input logic [3:0] op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_divrem(input logic [3:0] op);
        return op inside {OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative magnitude datapath: shift-add multiply and restoring divide, one bit per cycle.
// Operand magnitudes are taken on start; sign correction is left to the caller.

module alu_mc_muldiv #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start,
    input  logic             div,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             run_q;
    logic             div_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, m_q;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    always_comb begin
        a_mag = (sign && a[WIDTH-1]) ? -a : a;
        b_mag = (sign && b[WIDTH-1]) ? -b : b;

        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);

        // Partial remainder stays below the divisor, so the low WIDTH bits of the
        // difference are exact whenever the subtraction is taken.
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, m_q};
        div_diff = div_sh[WIDTH-1:0] - m_q;

        if (div_q) begin
            hi_n = div_ge ? div_diff : div_sh[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
        end

        busy = run_q;
        done = run_q && (cnt_q == '0);
        hi   = hi_q;
        lo   = lo_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
        end else if (flush) begin
            run_q <= 1'b0;
        end else if (start) begin
            run_q <= 1'b1;
            div_q <= div;
            cnt_q <= SHW'(WIDTH - 1);
            hi_q  <= '0;
            lo_q  <= a_mag;
            m_q   <= b_mag;
        end else if (run_q) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: handshake FSM, single-cycle ops, sign-fix stage and
// registered result/flags. Multiply and divide iterate in alu_mc_muldiv.

module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ofl,
    output logic             z,
    output logic             lt_zero,
    output logic             dvz
);

    state_e           state_q;
    logic [3:0]       op_q;
    logic             sign_q;
    logic [WIDTH-1:0] a_q, b_q;

    logic             accept, acc_dvz, start;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;

    always_comb begin
        in_ready = (state_q == StIdle) && (!out_valid || out_ready);
        accept   = in_valid && in_ready && !flush;
        acc_dvz  = is_divrem(op) && (b == '0);
        start    = accept && is_iter(op) && !acc_dvz;
    end

    alu_mc_muldiv #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .start (start),
        .div   (is_divrem(op)),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .busy  (md_busy),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // Single-cycle datapath
    logic [SHW-1:0]   shamt, ror_idx, rol_idx;
    logic [WIDTH-1:0] rol_r, ror_r;
    logic [WIDTH:0]   add_t, sub_t;
    logic             add_sovf, sub_sovf;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ofl, sc_live;

    always_comb begin
        shamt   = b[SHW-1:0];
        ror_idx = '0;
        rol_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ror_idx  = SHW'(i) + shamt;
            rol_idx  = SHW'(i) - shamt;
            ror_r[i] = a[ror_idx];
            rol_r[i] = a[rol_idx];
        end

        add_t    = {1'b0, a} + {1'b0, b};
        sub_t    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        add_sovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_t[WIDTH-1] != a[WIDTH-1]);
        sub_sovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_t[WIDTH-1] != a[WIDTH-1]);

        sc_res  = '0;
        sc_ofl  = 1'b0;
        sc_live = 1'b1;
        case (op)
            OP_ROL:  sc_res = rol_r;
            OP_SLL:  sc_res = a << shamt;
            OP_ROR:  sc_res = ror_r;
            OP_SRL:  sc_res = a >> shamt;
            OP_ADD: begin
                sc_res = add_t[WIDTH-1:0];
                sc_ofl = sign ? add_sovf : add_t[WIDTH];
            end
            OP_SUB: begin
                sc_res = sub_t[WIDTH-1:0];
                sc_ofl = sign ? sub_sovf : !sub_t[WIDTH];
            end
            OP_XOR:  sc_res = a ^ b;
            OP_AND:  sc_res = a & b;
            default: sc_live = 1'b0;
        endcase
    end

    // Sign-fix stage on the magnitude results
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic               fx_dvz;
    logic [WIDTH-1:0]   fx_res;
    logic               fx_ofl, mul_ofl;

    always_comb begin
        prod   = (sign_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -{md_hi, md_lo} : {md_hi, md_lo};
        quot   = (sign_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -md_lo : md_lo;
        rem    = (sign_q && a_q[WIDTH-1]) ? -md_hi : md_hi;
        fx_dvz = is_divrem(op_q) && (b_q == '0);

        mul_ofl = sign_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                         : (prod[2*WIDTH-1:WIDTH] != '0);

        fx_res = '0;
        fx_ofl = 1'b0;
        case (op_q)
            OP_MUL: begin
                fx_res = prod[WIDTH-1:0];
                fx_ofl = mul_ofl;
            end
            OP_MULH: begin
                fx_res = prod[2*WIDTH-1:WIDTH];
                fx_ofl = mul_ofl;
            end
            OP_DIV: begin
                fx_res = fx_dvz ? '1 : quot;
                // MIN / -1: the magnitude quotient already reads back as MIN
                fx_ofl = !fx_dvz && sign_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
            end
            OP_REM:  fx_res = fx_dvz ? a_q : rem;
            default: fx_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            result    <= '0;
            ofl       <= 1'b0;
            z         <= 1'b0;
            lt_zero   <= 1'b0;
            dvz       <= 1'b0;
            op_q      <= '0;
            sign_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else if (flush) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q   <= op;
                        sign_q <= sign;
                        a_q    <= a;
                        b_q    <= b;
                        if (is_iter(op)) begin
                            state_q <= acc_dvz ? StFix : StIter;
                        end else begin
                            result    <= sc_res;
                            ofl       <= sc_ofl;
                            z         <= sc_live && (sc_res == '0);
                            lt_zero   <= sign && sc_res[WIDTH-1];
                            dvz       <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                StIter: begin
                    if (md_done) begin
                        state_q <= StFix;
                    end else if (!md_busy) begin
                        state_q <= StIdle;
                    end
                end
                StFix: begin
                    result    <= fx_res;
                    ofl       <= fx_ofl;
                    z         <= (fx_res == '0);
                    lt_zero   <= sign_q && fx_res[WIDTH-1];
                    dvz       <= fx_dvz;
                    out_valid <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=16.

module tb_alu_mc;

    logic        clk, rst_n, flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op;
    logic        sign;
    logic [15:0] a, b, result;
    logic        ofl, z, lt_zero, dvz;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0]  o;
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ofl;
        logic        z;
        logic        lt;
        logic        dvz;
        logic [7:0]  lat;
    } vec_t;

    alu_mc #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sign      (sign),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ofl       (ofl),
        .z         (z),
        .lt_zero   (lt_zero),
        .dvz       (dvz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Present one op, wait for acceptance, return cycles from accept to out_valid.
    task automatic do_op(input logic [3:0] o, input logic s, input logic [15:0] aa,
                         input logic [15:0] bb, output int lat);
        int n;
        @(negedge clk);
        op = o; sign = s; a = aa; b = bb; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vectors(input vec_t v [], input string tag);
        int lat;
        for (int i = 0; i < v.size(); i++) begin
            do_op(v[i].o, v[i].s, v[i].a, v[i].b, lat);
            tests++;
            if (lat != int'(v[i].lat)) begin
                fails++;
                $display("FAIL %s[%0d] latency: got %0d expected %0d", tag, i, lat, v[i].lat);
            end
            tests++;
            if ({result, ofl, z, lt_zero, dvz} !== {v[i].res, v[i].ofl, v[i].z, v[i].lt, v[i].dvz})
            begin
                fails++;
                $display("FAIL %s[%0d] res/ofl/z/lt/dvz: got %h/%b/%b/%b/%b expected %h/%b/%b/%b/%b",
                         tag, i, result, ofl, z, lt_zero, dvz,
                         v[i].res, v[i].ofl, v[i].z, v[i].lt, v[i].dvz);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; sign = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({out_valid, in_ready, result, ofl, z, lt_zero, dvz} !== {1'b0, 1'b1, 16'h0, 4'b0}) begin
            fails++;
            $display("FAIL reset: got ov=%b ir=%b res=%h flags=%b%b%b%b expected ov=0 ir=1 res=0000 0000",
                     out_valid, in_ready, result, ofl, z, lt_zero, dvz);
        end
    endtask

    task automatic test_single_cycle();
        vec_t v [];
        v = new[13];
        v[0]  = '{4'b0100, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
        v[1]  = '{4'b0100, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        v[2]  = '{4'b0101, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        v[3]  = '{4'b0101, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        v[4]  = '{4'b0101, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        v[5]  = '{4'b0110, 1'b0, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        v[6]  = '{4'b0111, 1'b1, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        v[7]  = '{4'b0001, 1'b0, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        v[8]  = '{4'b0010, 1'b0, 16'h0001, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        v[9]  = '{4'b0011, 1'b1, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        v[10] = '{4'b0000, 1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        v[11] = '{4'b0000, 1'b0, 16'h8001, 16'h0010, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        v[12] = '{4'b1100, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        run_vectors(v, "single");
    endtask

    task automatic test_muldiv();
        vec_t v [];
        v = new[14];
        v[0]  = '{4'b1000, 1'b0, 16'h1234, 16'h0010, 16'h2340, 1'b1, 1'b0, 1'b0, 1'b0, 8'd18};
        v[1]  = '{4'b1001, 1'b0, 16'h1234, 16'h0010, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 8'd18};
        v[2]  = '{4'b1000, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd18};
        v[3]  = '{4'b1001, 1'b1, 16'hFFFD, 16'h0005, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd18};
        v[4]  = '{4'b1000, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd18};
        v[5]  = '{4'b1000, 1'b0, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd18};
        v[6]  = '{4'b1010, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 1'b0, 1'b1, 1'b0, 8'd18};
        v[7]  = '{4'b1011, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd18};
        v[8]  = '{4'b1010, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd18};
        v[9]  = '{4'b1010, 1'b0, 16'h0064, 16'h0007, 16'h000E, 1'b0, 1'b0, 1'b0, 1'b0, 8'd18};
        v[10] = '{4'b1011, 1'b0, 16'h0064, 16'h0007, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 8'd18};
        v[11] = '{4'b1010, 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 1'b0, 1'b0, 1'b1, 1'b0, 8'd18};
        v[12] = '{4'b1010, 1'b0, 16'h0042, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
        v[13] = '{4'b1011, 1'b0, 16'h0042, 16'h0000, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
        run_vectors(v, "muldiv");
    endtask

    task automatic test_back_to_back();
        int lat;
        @(posedge clk);
        #1 out_ready = 1'b0;
        do_op(4'b0000, 1'b0, 16'h8001, 16'h0001, lat);
        tests++;
        if (lat != 1 || result !== 16'h0003) begin
            fails++;
            $display("FAIL hold_rol: got lat=%0d res=%h expected lat=1 res=0003", lat, result);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 16'h0003}) begin
                fails++;
                $display("FAIL hold[%0d]: got ov=%b ir=%b res=%h expected ov=1 ir=0 res=0003",
                         i, out_valid, in_ready, result);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        op = 4'b0110; sign = 1'b0; a = 16'h0001; b = 16'h0003; in_valid = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready: got in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        tests++;
        if ({out_valid, result} !== {1'b1, 16'h0002}) begin
            fails++;
            $display("FAIL b2b_result: got ov=%b res=%h expected ov=1 res=0002", out_valid, result);
        end
    endtask

    task automatic start_mul_and_run(input int cycles);
        @(negedge clk);
        op = 4'b1000; sign = 1'b0; a = 16'h1234; b = 16'h0010; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        do_op(4'b0100, 1'b1, 16'h7FFF, 16'h0001, lat);
        start_mul_and_run(5);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        tests++;
        if ({out_valid, in_ready, result, ofl, z, lt_zero, dvz} !==
            {1'b0, 1'b1, 16'h8000, 4'b1010}) begin
            fails++;
            $display("FAIL flush_mul: got ov=%b ir=%b res=%h flags=%b%b%b%b expected ov=0 ir=1 res=8000 1010",
                     out_valid, in_ready, result, ofl, z, lt_zero, dvz);
        end
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL flush_residue: got %0d out_valid cycles expected 0", seen);
        end
        // Accept presented in the flush cycle must be dropped
        @(negedge clk);
        op = 4'b0100; sign = 1'b0; a = 16'h0001; b = 16'h0001; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 16'h8000}) begin
            fails++;
            $display("FAIL flush_accept: got ov=%b ir=%b res=%h expected ov=0 ir=1 res=8000",
                     out_valid, in_ready, result);
        end
        do_op(4'b0110, 1'b0, 16'hAAAA, 16'h5555, lat);
        tests++;
        if (lat != 1 || result !== 16'hFFFF) begin
            fails++;
            $display("FAIL post_flush: got lat=%0d res=%h expected lat=1 res=FFFF", lat, result);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        do_op(4'b1010, 1'b0, 16'h0042, 16'h0000, lat);
        start_mul_and_run(5);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tests++;
        if ({out_valid, in_ready, result, ofl, z, lt_zero, dvz} !== {1'b0, 1'b1, 16'h0, 4'b0}) begin
            fails++;
            $display("FAIL reset_mul: got ov=%b ir=%b res=%h flags=%b%b%b%b expected ov=0 ir=1 res=0000 0000",
                     out_valid, in_ready, result, ofl, z, lt_zero, dvz);
        end
        do_op(4'b1000, 1'b0, 16'h0003, 16'h0004, lat);
        tests++;
        if (lat != 18 || result !== 16'h000C) begin
            fails++;
            $display("FAIL post_reset_mul: got lat=%0d res=%h expected lat=18 res=000C", lat, result);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
